stg_if_fetch: RTL and testbench
===============================

# stg_if_fetch

Instruction-fetch stage of the diad pipeline, sitting between the instruction-address (IA) stage and the decode stage (the IF→ID boundary). It accepts PCs from IA, issues them to instruction memory, and pairs each in-order response with its PC. It presents {pc, instr} to ID through a valid/ready queue, and discards in-flight fetches on a redirect flush.

## Interface
Parameters:
- PC_W, 24, PC and imem address width
- INSTR_W, 24, instruction word width
- MAX_OUT, 2, maximum outstanding imem requests (power of two, ≥1)

Ports:
- iw_clk  in  1  clock
- iw_rst  in  1  asynchronous, active-low reset
- iw_ia_valid  in  1  IA presents a PC
- iw_ia_pc  in  PC_W  PC to fetch
- ow_ia_ready  out  1  fetch accepts PC this cycle
- ow_imem_req  out  1  imem request
- ow_imem_addr  out  PC_W  imem address
- iw_imem_gnt  in  1  imem accepts request this cycle
- iw_imem_rvalid  in  1  response valid (in order, ≥1 cycle after grant)
- iw_imem_rdata  in  INSTR_W  response data
- ow_ifid_valid  out  1  entry available to ID
- ow_ifid_pc  out  PC_W  PC of head entry
- ow_ifid_instr  out  INSTR_W  instruction of head entry
- iw_id_ready  in  1  ID consumes head this cycle
- iw_flush  in  1  redirect; kill everything in flight

## Operation
- Credit = QDEPTH − (queue occupancy + live outstanding). QDEPTH is 2 with the skid buffer and 1 without it.
- ow_imem_req = iw_ia_valid & (credit>0) & (outstanding<MAX_OUT) & ~iw_flush. ow_imem_addr = iw_ia_pc.
- ow_ia_ready = ow_imem_req & iw_imem_gnt. An IA transfer and an imem issue are the same event.
- On issue, push iw_ia_pc into a PC tag FIFO of depth MAX_OUT and increment the outstanding count.
- On iw_imem_rvalid: pop the tag FIFO and decrement outstanding.
  - If the kill count > 0, drop the response and decrement kill.
  - Otherwise write {tag, rdata} into the output queue.
- Output queue: head drives ow_ifid_*. Pop on ow_ifid_valid & iw_id_ready.
- Flush:
  - Output queue is emptied.
  - Kill count = outstanding count after this cycle's response is accounted.
  - A response arriving in the flush cycle is dropped.
  - No request is issued in the flush cycle.
  - A pop by ID in the flush cycle is permitted and harmless.
- Simultaneous push and pop on a full queue are legal. Credit accounting guarantees no overflow.
- iw_imem_rvalid with outstanding = 0 is a protocol error. It is ignored, and flagged by an assertion.

## Timing
- Reset values: ow_ia_ready=0 (follows iw_ia_valid after reset), ow_imem_req=0, ow_imem_addr=0, ow_ifid_valid=0, ow_ifid_pc=0, ow_ifid_instr=0. Queue, tag FIFO, outstanding and kill are all cleared.
- Latency: response in cycle N → ow_ifid_valid high in cycle N+1 (registered queue). There is no combinational path from rvalid to ow_ifid_valid.
- Throughput with a 1-cycle imem and ID always ready: one instruction per cycle, sustained.
- ow_ifid_* are stable while valid & ~ready.
- Reset asserted mid-operation: all state is cleared asynchronously. imem is reset on the same rail, so no stale responses arrive.
- Back-to-back flushes: each flush recomputes kill from the current outstanding count. Kill never exceeds MAX_OUT.

## Configuration
- DIAD_IF_SKID_EN defined:
  - Output queue is 2 entries (skid buffer).
  - Full throughput with a 1-cycle imem even when iw_id_ready is combinationally late.
- DIAD_IF_SKID_EN undefined:
  - Single output register, so credit is at most 1.
  - Fetch issues only when the register is empty or being popped and nothing is outstanding.
  - Peak throughput is one instruction every 2 cycles.
  - Smaller area. All other behaviour is identical.

## Structure
- PC_W and INSTR_W defaults come from the shared sizes header.
- The {pc, instr} entry width is a shared constant, because ID consumes the same layout.
- One sub-module, if_fifo: parameterised depth and width, synchronous push/pop/clear, async active-low reset, with full/empty/count outputs.
  - Instantiated twice: PC tag FIFO (depth MAX_OUT) and output queue (depth QDEPTH).

## Test plan
- Reset then stream: PCs 0x000000..0x000005, 1-cycle imem, ID ready → six entries out on consecutive cycles in PC order, data = imem contents. First ow_ifid_valid appears 2 cycles after the first grant.
- ID stall: ID ready low for 4 cycles mid-stream → ow_ia_ready drops once credit reaches 0. Head stays at the same pc/instr throughout. Nothing is lost or duplicated when ready returns.
- Flush with 2 outstanding: issue 0x10 and 0x11, assert iw_flush before either responds, then issue 0x40 → both stale responses are dropped. First ID entry is pc=0x40.
- Flush coincident with response and ID pop → response dropped, queue empty next cycle, no assertion fires.
- Grant withheld 3 cycles (iw_imem_gnt=0) → ow_ia_ready=0 and no tag push. The PC is accepted on the first granted cycle.
- Async reset asserted mid-stream → all outputs 0 within the same cycle (no clock edge needed). Stream restarts cleanly after release.
- Each scenario is run with and without DIAD_IF_SKID_EN. The stream case must show throughput of 1/cycle and 1/2-cycle respectively.

Source files
------------

// File: rtl/stg_if_fetch_pkg.sv
// Shared IF/ID sizes and output-queue depth for the diad fetch stage.
// DIAD_IF_SKID_EN selects a 2-entry skid queue; otherwise a single output register.
package stg_if_fetch_pkg;

  localparam int DIAD_PC_W    = 24;
  localparam int DIAD_INSTR_W = 24;

`ifdef DIAD_IF_SKID_EN
  localparam int IF_QDEPTH = 2;
`else
  localparam int IF_QDEPTH = 1;
`endif

  // ID unpacks the same {pc, instr} layout, so both sides size it here
  function automatic int ifid_entry_w(input int pc_w, input int instr_w);
    return pc_w + instr_w;
  endfunction

  localparam int DIAD_IFID_W = ifid_entry_w(DIAD_PC_W, DIAD_INSTR_W);

endpackage

// File: rtl/stg_if_fetch_if_fifo.sv
// Generic synchronous FIFO: push/pop/clear, head shown combinationally, full/empty/count.
// Clear wins over push/pop; push on full is accepted only together with a pop.
module stg_if_fetch_if_fifo
  import stg_if_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = DIAD_IFID_W,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_full    = (r_cnt == CW'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign o_count   = r_cnt;
  assign o_dout    = r_mem[r_rd];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_clr) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= i_din;
        r_wr        <= f_inc(r_wr);
      end
      if (w_do_pop) r_rd <= f_inc(r_rd);
      r_cnt <= r_cnt + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/stg_if_fetch.sv
// IF stage: issues IA PCs to imem, tags in-order responses with their PC, queues {pc,instr} for ID.
// Build option DIAD_IF_SKID_EN: 2-entry output skid queue (1/cycle); default single register (1/2 cycles).
module stg_if_fetch
  import stg_if_fetch_pkg::*;
#(
  parameter int PC_W    = DIAD_PC_W,
  parameter int INSTR_W = DIAD_INSTR_W,
  parameter int MAX_OUT = 2
) (
  input  logic               iw_clk,
  input  logic               iw_rst,
  input  logic               iw_ia_valid,
  input  logic [PC_W-1:0]    iw_ia_pc,
  output logic               ow_ia_ready,
  output logic               ow_imem_req,
  output logic [PC_W-1:0]    ow_imem_addr,
  input  logic               iw_imem_gnt,
  input  logic               iw_imem_rvalid,
  input  logic [INSTR_W-1:0] iw_imem_rdata,
  output logic               ow_ifid_valid,
  output logic [PC_W-1:0]    ow_ifid_pc,
  output logic [INSTR_W-1:0] ow_ifid_instr,
  input  logic               iw_id_ready,
  input  logic               iw_flush
);

  localparam int QDEPTH  = IF_QDEPTH;
  localparam int ENTRY_W = ifid_entry_w(PC_W, INSTR_W);
  localparam int OCW     = $clog2(MAX_OUT + 1);
  localparam int QCW     = $clog2(QDEPTH + 1);
  localparam int UW      = OCW + QCW;

  logic [OCW-1:0]     w_out;
  logic [OCW-1:0]     r_kill;
  logic [OCW-1:0]     w_live;
  logic [QCW-1:0]     w_occ;
  logic [QCW-1:0]     w_occ_eff;
  logic [UW-1:0]      w_used;
  logic [PC_W-1:0]    w_tag;
  logic [ENTRY_W-1:0] w_head;
  logic               w_tag_full, w_tag_empty, w_q_full, w_q_empty;
  logic               w_credit, w_req, w_issue, w_rsp, w_qpush, w_pop;

  // Slots already claimed: queued entries not leaving this cycle plus fetches that will land
  assign w_pop     = ~w_q_empty & iw_id_ready;
  assign w_live    = w_out - r_kill;
  assign w_occ_eff = w_occ - QCW'(w_pop);
  assign w_used    = UW'(w_occ_eff) + UW'(w_live);
  assign w_credit  = (w_used < UW'(QDEPTH));

  assign w_req   = iw_rst & iw_ia_valid & w_credit & ~w_tag_full & ~iw_flush;
  assign w_issue = w_req & iw_imem_gnt;
  assign w_rsp   = iw_imem_rvalid & ~w_tag_empty;
  assign w_qpush = w_rsp & (r_kill == '0) & ~iw_flush;

  assign ow_imem_req   = w_req;
  assign ow_imem_addr  = iw_rst ? iw_ia_pc : '0;
  assign ow_ia_ready   = w_issue;
  assign ow_ifid_valid = ~w_q_empty;
  assign ow_ifid_pc    = w_head[ENTRY_W-1 -: PC_W];
  assign ow_ifid_instr = w_head[INSTR_W-1:0];

  // Responses still owed to a redirected path; they drain through the tag FIFO unqueued
  always_ff @(posedge iw_clk or negedge iw_rst) begin
    if (!iw_rst) begin
      r_kill <= '0;
    end else if (iw_flush) begin
      r_kill <= w_out - OCW'(w_rsp);
    end else if (w_rsp && (r_kill != '0)) begin
      r_kill <= r_kill - OCW'(1);
    end
  end

  stg_if_fetch_if_fifo #(.DEPTH(MAX_OUT), .WIDTH(PC_W)) u_tag_fifo (
    .i_clk   (iw_clk),
    .i_rst_n (iw_rst),
    .i_push  (w_issue),
    .i_din   (iw_ia_pc),
    .i_pop   (w_rsp),
    .i_clr   (1'b0),
    .o_dout  (w_tag),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty),
    .o_count (w_out)
  );

  stg_if_fetch_if_fifo #(.DEPTH(QDEPTH), .WIDTH(ENTRY_W)) u_out_q (
    .i_clk   (iw_clk),
    .i_rst_n (iw_rst),
    .i_push  (w_qpush),
    .i_din   ({w_tag, iw_imem_rdata}),
    .i_pop   (w_pop),
    .i_clr   (iw_flush),
    .o_dout  (w_head),
    .o_full  (w_q_full),
    .o_empty (w_q_empty),
    .o_count (w_occ)
  );

  a_rvalid_idle: assert property (@(posedge iw_clk) disable iff (!iw_rst)
    !(iw_imem_rvalid && w_tag_empty));

  a_q_overflow: assert property (@(posedge iw_clk) disable iff (!iw_rst)
    !(w_qpush && w_q_full && !w_pop));

endmodule

// File: tb/tb_stg_if_fetch.sv
// Bench for stg_if_fetch: directed scenarios plus random traffic against a PC-order reference queue.
// Same bench covers both builds (DIAD_IF_SKID_EN defined or not).
module tb_stg_if_fetch;

`ifdef DIAD_IF_SKID_EN
  localparam int QD = 2;
`else
  localparam int QD = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ia_valid = 1'b0, ia_ready, imem_req, gnt = 1'b0, rvalid = 1'b0;
  logic [23:0] ia_pc = '0, imem_addr, rdata = '0, ifid_pc, ifid_instr;
  logic        ifid_valid, id_ready = 1'b0, flush = 1'b0;

  always #5 clk = ~clk;

  stg_if_fetch #(.PC_W(24), .INSTR_W(24), .MAX_OUT(2)) dut (
    .iw_clk(clk), .iw_rst(rst_n),
    .iw_ia_valid(ia_valid), .iw_ia_pc(ia_pc), .ow_ia_ready(ia_ready),
    .ow_imem_req(imem_req), .ow_imem_addr(imem_addr), .iw_imem_gnt(gnt),
    .iw_imem_rvalid(rvalid), .iw_imem_rdata(rdata),
    .ow_ifid_valid(ifid_valid), .ow_ifid_pc(ifid_pc), .ow_ifid_instr(ifid_instr),
    .iw_id_ready(id_ready), .iw_flush(flush)
  );

  typedef struct { logic [23:0] pc; int due; } req_t;
  req_t        pend[$];
  logic [23:0] exp_q[$];
  int  n_chk = 0, n_err = 0, cyc = 0, last_due = 0, lat_lo = 1, lat_hi = 1;
  int  delivered, first_out, last_out, first_issue;
  bit  last_issue, hold_vld, prev_flush, got_first, coinc, s_ia_ready, s_req;
  logic [23:0] hold_pc, hold_instr, first_pc_out;

  function automatic logic [23:0] imem_word(input logic [23:0] pc);
    logic [31:0] t;
    t = ({8'h0, pc} * 32'd40503) ^ 32'h00A5C3F1;
    return t[23:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    delivered = 0; first_out = -1; last_out = -1; first_issue = -1;
    got_first = 1'b0; coinc = 1'b0;
  endtask

  // One clock: drive imem response, sample outputs, update reference, advance.
  task automatic cycle();
    req_t r;
    bit   iss, pop;
    int   lat;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      rvalid = 1'b1; rdata = imem_word(pend[0].pc);
    end else begin
      rvalid = 1'b0; rdata = 24'($urandom);
    end
    #1;
    if (hold_vld) begin
      chk("hold_valid", ifid_valid, 1);
      chk("hold_pc", ifid_pc, hold_pc);
      chk("hold_instr", ifid_instr, hold_instr);
    end
    if (prev_flush) chk("empty_after_flush", ifid_valid, 0);
    iss = imem_req & gnt;
    s_ia_ready = ia_ready; s_req = imem_req;
    chk("ia_ready", ia_ready, iss);
    chk("req_without_valid", imem_req & ~ia_valid, 0);
    if (imem_req) chk("imem_addr", imem_addr, ia_pc);
    if (flush) chk("req_in_flush", imem_req, 0);
    if (flush && rvalid && ifid_valid && id_ready) coinc = 1'b1;
    pop = ifid_valid & id_ready;
    if (pop) begin
      if (exp_q.size() == 0) chk("spurious_out", ifid_valid, 0);
      else begin
        chk("out_pc", ifid_pc, exp_q[0]);
        chk("out_instr", ifid_instr, imem_word(exp_q[0]));
        void'(exp_q.pop_front());
      end
      if (!got_first) begin got_first = 1'b1; first_pc_out = ifid_pc; end
      delivered++;
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
    end
    if (flush) exp_q.delete();
    else if (iss) exp_q.push_back(ia_pc);
    chk("credit_bound", exp_q.size() <= QD, 1);
    if (rvalid) void'(pend.pop_front());
    if (iss) begin
      lat = $urandom_range(lat_hi, lat_lo);
      r.pc = ia_pc;
      r.due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = r.due;
      pend.push_back(r);
      if (first_issue < 0) first_issue = cyc;
    end
    last_issue = iss;
    hold_vld = ifid_valid & ~id_ready & ~flush;
    hold_pc = ifid_pc; hold_instr = ifid_instr;
    prev_flush = flush;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic drain();
    int k = 0;
    ia_valid = 1'b0; flush = 1'b0; id_ready = 1'b1; gnt = 1'b1;
    while ((exp_q.size() > 0 || pend.size() > 0) && k < 60) begin cycle(); k++; end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic run_stream(input logic [23:0] base, input int n, input int stall_at,
                            input int stall_len, input int flush_at, output bit stall_rdy);
    int issued = 0, k = 0;
    gnt = 1'b1; lat_lo = 1; lat_hi = 1; stall_rdy = 1'b1;
    while (issued < n && k < 200) begin
      ia_valid = 1'b1; ia_pc = base + 24'(issued);
      id_ready = !(k >= stall_at && k < stall_at + stall_len);
      flush = (k == flush_at);
      cycle();
      if (k == stall_at + stall_len - 1) stall_rdy = s_ia_ready;
      if (last_issue) issued++;
      k++;
    end
    chk("stream_issue_done", issued, n);
    drain();
  endtask

  task automatic issue_one(input logic [23:0] pc, input int bound);
    int k = 0;
    ia_valid = 1'b1; ia_pc = pc;
    do begin cycle(); k++; end while (!last_issue && k < bound);
    ia_valid = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_ia_ready"}, ia_ready, 0);
    chk({tag, "_imem_req"}, imem_req, 0);
    chk({tag, "_imem_addr"}, imem_addr, 0);
    chk({tag, "_ifid_valid"}, ifid_valid, 0);
    chk({tag, "_ifid_pc"}, ifid_pc, 0);
    chk({tag, "_ifid_instr"}, ifid_instr, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit sr;
    // Reset state, with IA and grant active so gating is exercised
    ia_valid = 1'b1; gnt = 1'b1; ia_pc = 24'h123456;
    #12;
    check_outputs_zero("rst");
    ia_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Stream 0..5, 1-cycle imem, ID always ready
    clear_stats();
    run_stream(24'h0, 6, 1000, 0, -1, sr);
    chk("stream_count", delivered, 6);
    chk("first_valid_latency", first_out - first_issue, 2);
    chk("stream_span", last_out - first_out, (QD == 2) ? 5 : 10);

    // ID stall of 4 cycles mid-stream
    clear_stats();
    run_stream(24'h100, 8, 4, 4, -1, sr);
    chk("stall_ia_ready", sr, 0);
    chk("stall_count", delivered, 8);

    // Flush with fetches outstanding on a slow imem
    clear_stats();
    id_ready = 1'b1; gnt = 1'b1; lat_lo = 3; lat_hi = 3;
    issue_one(24'h10, 10);
    issue_one(24'h11, 2);
    ia_valid = 1'b1; ia_pc = 24'h40; flush = 1'b1;
    cycle();
    flush = 1'b0;
    issue_one(24'h40, 12);
    drain();
    chk("flush_first_pc", first_pc_out, 24'h40);
    chk("flush_count", delivered, 1);

    // Flush landing on a response and an ID pop
    clear_stats();
    run_stream(24'h500, 6, 1000, 0, 3, sr);
    chk("flush_coincident", coinc, (QD == 2) ? 1 : 0);

    // Grant withheld for 3 cycles
    clear_stats();
    ia_valid = 1'b1; ia_pc = 24'h200; gnt = 1'b0; id_ready = 1'b1;
    repeat (3) begin
      cycle();
      chk("gnt_wait_ready", s_ia_ready, 0);
      chk("gnt_wait_req", s_req, 1);
    end
    gnt = 1'b1;
    cycle();
    chk("gnt_accept", s_ia_ready, 1);
    drain();
    chk("gnt_count", delivered, 1);

    // Async reset mid-stream
    ia_valid = 1'b1; gnt = 1'b1; id_ready = 1'b1; lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 3; i++) begin ia_pc = 24'h600 + 24'(i); cycle(); end
    #1 rst_n = 1'b0;
    #1 check_outputs_zero("async_rst");
    pend.delete(); exp_q.delete();
    hold_vld = 1'b0; prev_flush = 1'b0; last_due = 0; ia_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_stats();
    run_stream(24'h300, 6, 1000, 0, -1, sr);
    chk("restart_count", delivered, 6);

    // Random traffic
    lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 600; i++) begin
      ia_valid = ($urandom_range(3, 0) != 0);
      ia_pc    = 24'($urandom);
      gnt      = ($urandom_range(3, 0) != 0);
      id_ready = ($urandom_range(2, 0) != 0);
      flush    = ($urandom_range(19, 0) == 0);
      cycle();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
